// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//
// Command sequencer between the instruction decoder and the registers/alu
// pair. An ALU command runs a read-A / read-B / execute / write-back sequence.
// A load-immediate command writes `imm` straight to `dst`. Each command ends
// with a one-cycle `done` pulse.
//
// Ports
//   clk, rst            : clock and synchronous active-high reset
//   start, load_imm     : command request and command type (1 = load imm)
//   opcode, src_a,      : command fields, latched when the command is accepted
//   src_b, dst, imm
//   ready               : high while idle and able to accept a command
//   done, result        : completion pulse and value of the last write
//   reg_addr, reg_rd,   : register file access port
//   reg_wr, reg_wdata,
//   reg_rdata
//   alu_opcode, alu_a,  : ALU operand/opcode drive, plus the ALU result
//   alu_b, alu_y
// -----------------------------------------------------------------------------
module alu_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       load_imm,
  input  logic [2:0] opcode,
  input  logic [1:0] src_a,
  input  logic [1:0] src_b,
  input  logic [1:0] dst,
  input  logic [7:0] imm,
  output logic       ready,
  output logic       done,
  output logic [7:0] result,
  output logic [1:0] reg_addr,
  output logic       reg_rd,
  output logic       reg_wr,
  output logic [7:0] reg_wdata,
  input  logic [7:0] reg_rdata,
  output logic [2:0] alu_opcode,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_y
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    EXEC = 3'd3,
    WB   = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t     state;
  logic [2:0] op_q;
  logic [1:0] src_b_q;
  logic [1:0] dst_q;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic [7:0] res_q;

  // The ALU is driven continuously from the latched opcode and operands.
  assign alu_opcode = op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;

  // The outputs are registered. Each one is loaded on the edge that enters
  // the state it belongs to. This keeps the register file port glitch-free.
  // src_a needs no latch, because its address is loaded on the accept edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= '0;
      src_b_q   <= '0;
      dst_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      result    <= '0;
      ready     <= 1'b1;
      done      <= 1'b0;
      reg_addr  <= '0;
      reg_rd    <= 1'b0;
      reg_wr    <= 1'b0;
      reg_wdata <= '0;
    end else begin
      // NOTE: non-blocking defaults here are overridden by later assignments
      // in the case below. Every state therefore only states what differs,
      // and the port returns to idle values unless a state drives it.
      ready     <= 1'b0;
      done      <= 1'b0;
      reg_addr  <= '0;
      reg_rd    <= 1'b0;
      reg_wr    <= 1'b0;
      reg_wdata <= '0;

      case (state)
        IDLE: begin
          if (start) begin
            op_q    <= opcode;
            src_b_q <= src_b;
            dst_q   <= dst;
            if (load_imm) begin
              res_q     <= imm;
              reg_addr  <= dst;
              reg_wr    <= 1'b1;
              reg_wdata <= imm;
              state     <= WB;
            end else begin
              reg_addr <= src_a;
              reg_rd   <= 1'b1;
              state    <= RD_A;
            end
          end else begin
            ready <= 1'b1;
          end
        end
        RD_A: begin
          a_q      <= reg_rdata;
          reg_addr <= src_b_q;
          reg_rd   <= 1'b1;
          state    <= RD_B;
        end
        RD_B: begin
          b_q   <= reg_rdata;
          state <= EXEC;
        end
        EXEC: begin
          res_q     <= alu_y;
          reg_addr  <= dst_q;
          reg_wr    <= 1'b1;
          reg_wdata <= alu_y;
          state     <= WB;
        end
        WB: begin
          done   <= 1'b1;
          result <= res_q;
          state  <= DONE;
        end
        DONE: begin
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
//
// Self-checking bench for alu_sequencer. It provides a 4-entry register file
// and an 8-bit ALU around the DUT. It runs directed and random commands and
// checks them against an architectural model. That model is an array of
// register values plus the expected latency of each command type.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       load_imm;
  logic [2:0] opcode;
  logic [1:0] src_a;
  logic [1:0] src_b;
  logic [1:0] dst;
  logic [7:0] imm;
  logic       ready;
  logic       done;
  logic [7:0] result;
  logic [1:0] reg_addr;
  logic       reg_rd;
  logic       reg_wr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic [2:0] alu_opcode;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_y;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .load_imm   (load_imm),
    .opcode     (opcode),
    .src_a      (src_a),
    .src_b      (src_b),
    .dst        (dst),
    .imm        (imm),
    .ready      (ready),
    .done       (done),
    .result     (result),
    .reg_addr   (reg_addr),
    .reg_rd     (reg_rd),
    .reg_wr     (reg_wr),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (reg_rdata),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_y      (alu_y)
  );

  // ALU behaviour. Opcode 000 adds and 001 subtracts, and both wrap modulo 256.
  function automatic logic [7:0] alu_fn(input logic [2:0] op,
                                        input logic [7:0] a,
                                        input logic [7:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      3'd6:    return a;
      default: return b;
    endcase
  endfunction

  // Register file and ALU seen by the DUT.
  logic [7:0] mem [4];
  assign reg_rdata = reg_rd ? mem[reg_addr] : 8'h00;
  assign alu_y     = alu_fn(alu_opcode, alu_a, alu_b);

  // Bus monitor: applies writes and records port activity.
  int         cyc      = 0;
  int         wr_cnt   = 0;
  int         done_cnt = 0;
  int         both_cnt = 0;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [1:0] rd_q[$];

  initial for (int i = 0; i < 4; i++) mem[i] = 8'h00;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reg_wr) begin
      mem[reg_addr] <= reg_wdata;
      wr_cnt  = wr_cnt + 1;
      wr_addr = reg_addr;
      wr_data = reg_wdata;
    end
    if (reg_rd) rd_q.push_back(reg_addr);
    if (reg_rd && reg_wr) both_cnt = both_cnt + 1;
    if (done) done_cnt = done_cnt + 1;
  end

  // Reference model: architectural register contents.
  logic [7:0] exp_regs [4];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         prev_acc = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Issue one command and check the whole transaction. Call at a negedge.
  // keep:     leave start high after acceptance.
  // pulse_at: cycle after acceptance in which to pulse a junk start (0 = none).
  // gap:      expected cycles since the previous acceptance (0 = unchecked).
  task automatic do_cmd(input bit ld, input logic [2:0] op,
                        input logic [1:0] a, input logic [1:0] b,
                        input logic [1:0] d, input logic [7:0] im,
                        input bit keep, input int pulse_at, input int gap);
    logic [7:0] ea;
    logic [7:0] eb;
    logic [7:0] exp;
    int         wr0;
    int         acc;
    int         lat;
    ea  = exp_regs[a];
    eb  = exp_regs[b];
    exp = ld ? im : alu_fn(op, ea, eb);
    load_imm = ld; opcode = op; src_a = a; src_b = b; dst = d; imm = im;
    start = 1'b1;
    for (int t = 0; t < 20 && !ready; t++) @(negedge clk);
    if (!ready) begin
      check("ready_timeout", 0, 1);
      start = 1'b0;
      return;
    end
    acc = cyc;
    if (gap > 0) check("accept_gap", acc - prev_acc, gap);
    prev_acc = acc;
    rd_q.delete();
    wr0 = wr_cnt;
    @(negedge clk);
    start    = keep;
    opcode   = 3'($urandom);
    src_a    = 2'($urandom);
    src_b    = 2'($urandom);
    dst      = 2'($urandom);
    imm      = 8'($urandom);
    load_imm = 1'($urandom);
    lat = 1;
    while (!done && lat < 20) begin
      if (lat == pulse_at) begin
        start = 1'b1; load_imm = 1'b1; dst = ~d; imm = 8'hAA;
      end
      if (pulse_at > 0 && lat == pulse_at + 1) start = keep;
      @(negedge clk);
      lat++;
    end
    check("done_latency", lat, ld ? 2 : 5);
    check("result", result, exp);
    check("write_count", wr_cnt - wr0, 1);
    check("write_addr", wr_addr, d);
    check("write_data", wr_data, exp);
    if (ld) begin
      check("read_count", rd_q.size(), 0);
    end else begin
      check("read_count", rd_q.size(), 2);
      if (rd_q.size() == 2) begin
        check("read_addr_a", rd_q[0], a);
        check("read_addr_b", rd_q[1], b);
      end
      check("alu_a", alu_a, ea);
      check("alu_b", alu_b, eb);
    end
    exp_regs[d] = exp;
  endtask

  initial begin
    int wr0;
    int d0;
    for (int i = 0; i < 4; i++) exp_regs[i] = 8'h00;
    rst = 1'b1; start = 1'b0; load_imm = 1'b0; opcode = '0;
    src_a = '0; src_b = '0; dst = '0; imm = '0;

    // Reset held for three cycles; outputs must stay at their reset values.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_ready", ready, 1);
      check("rst_done", done, 0);
      check("rst_rd_wr", {reg_rd, reg_wr}, 0);
      check("rst_result", result, 0);
      check("rst_addr_wdata", {reg_addr, reg_wdata}, 0);
      check("rst_alu", {alu_opcode, alu_a, alu_b}, 0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Load-immediate commands, then add and subtract.
    do_cmd(1, 3'd0, 2'd0, 2'd0, 2'd0, 8'h03, 0, 0, 0);
    @(negedge clk);
    do_cmd(1, 3'd0, 2'd0, 2'd0, 2'd1, 8'h02, 0, 0, 0);
    @(negedge clk);
    do_cmd(0, 3'd0, 2'd0, 2'd1, 2'd2, 8'h00, 0, 0, 0);
    check("add_value", exp_regs[2], 8'h05);
    @(negedge clk);
    do_cmd(0, 3'd1, 2'd0, 2'd1, 2'd3, 8'h00, 0, 0, 0);
    @(negedge clk);

    // Wrap-around with src_a = src_b = dst, then read R0 back.
    do_cmd(1, 3'd0, 2'd0, 2'd0, 2'd0, 8'hFF, 0, 0, 0);
    @(negedge clk);
    do_cmd(0, 3'd0, 2'd0, 2'd0, 2'd0, 8'h00, 0, 0, 0);
    @(negedge clk);
    do_cmd(0, 3'd6, 2'd0, 2'd1, 2'd1, 8'h00, 0, 0, 0);
    check("readback_r0", result, 8'hFE);
    @(negedge clk);

    // Start held high: each command is accepted on the first ready cycle.
    do_cmd(0, 3'd2, 2'd1, 2'd3, 2'd2, 8'h00, 1, 0, 0);
    do_cmd(0, 3'd1, 2'd3, 2'd0, 2'd3, 8'h00, 1, 0, 6);
    do_cmd(1, 3'd0, 2'd0, 2'd0, 2'd1, 8'h5A, 1, 0, 6);
    do_cmd(1, 3'd0, 2'd0, 2'd0, 2'd2, 8'hC3, 1, 0, 3);
    do_cmd(0, 3'd4, 2'd1, 2'd2, 2'd0, 8'h00, 0, 0, 3);
    @(negedge clk);

    // A start pulse during RD_B must be ignored.
    do_cmd(0, 3'd3, 2'd1, 2'd2, 2'd3, 8'h00, 0, 2, 0);
    @(negedge clk);

    // Reset during EXEC: no write, no done, and ready on the next cycle.
    load_imm = 1'b0; opcode = 3'd0; src_a = 2'd1; src_b = 2'd2; dst = 2'd3;
    start = 1'b1;
    for (int t = 0; t < 20 && !ready; t++) @(negedge clk);
    check("rst_exec_accept", ready, 1);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    wr0 = wr_cnt;
    d0  = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_exec_ready", ready, 1);
    check("rst_exec_done", done, 0);
    for (int i = 0; i < 6; i++) @(negedge clk);
    check("rst_exec_no_write", wr_cnt - wr0, 0);
    check("rst_exec_no_done", done_cnt - d0, 0);
    check("rst_exec_dst", mem[3], exp_regs[3]);

    // Randomized commands.
    for (int i = 0; i < 30; i++) begin
      do_cmd(1'($urandom), 3'($urandom), 2'($urandom), 2'($urandom),
             2'($urandom), 8'($urandom), 0, 0, 0);
      @(negedge clk);
    end

    check("rd_wr_overlap", both_cnt, 0);
    for (int i = 0; i < 4; i++) check("final_reg", mem[i], exp_regs[i]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Hardware command sequencer that drives the 4-entry register file and the 8-bit ALU. It performs in RTL the read/execute/write sequence otherwise hand-driven by a bench: read two operands from the register file, present them with an opcode to the ALU, and write the result back. It also supports loading an immediate into a register. It sits between the future instruction decoder (command side) and the existing `registers`/`alu` pair (datapath side).

## Interface
- No parameters. Data width is fixed at 8, register address width at 2, and opcode width at 3.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: command request, sampled only when `ready`=1.
- `load_imm` input 1: command type. 1 = write `imm` to `dst`; 0 = ALU operation.
- `opcode` input 3: ALU opcode for the command.
- `src_a` input 2: register address of operand A.
- `src_b` input 2: register address of operand B.
- `dst` input 2: destination register address.
- `imm` input 8: immediate value, used only when `load_imm`=1.
- `ready` output 1: high in IDLE only.
- `done` output 1: one-cycle pulse when the command completes.
- `result` output 8: value written by the last completed command; held until the next completion.
- `reg_addr` output 2: register file address.
- `reg_rd` output 1: register file read enable.
- `reg_wr` output 1: register file write enable.
- `reg_wdata` output 8: register file write data.
- `reg_rdata` input 8: register file read data, combinational from `reg_addr` while `reg_rd`=1.
- `alu_opcode` output 3: opcode driven to the ALU.
- `alu_a` output 8: operand A driven to the ALU.
- `alu_b` output 8: operand B driven to the ALU.
- `alu_y` input 8: ALU result, combinational.

## Operation
- FSM states: IDLE, RD_A, RD_B, EXEC, WB, DONE.
- IDLE, with `start`=1:
  - Latch `opcode`, `src_a`, `src_b`, `dst`, `imm` into internal registers.
  - If `load_imm`=1, set `res_q`=`imm` and go to WB; otherwise go to RD_A.
- IDLE, with `start`=0: stay in IDLE.
- RD_A: `reg_addr`=`src_a_q`, `reg_rd`=1. Capture `reg_rdata` into `a_q` at the end of the cycle, then go to RD_B.
- RD_B: `reg_addr`=`src_b_q`, `reg_rd`=1. Capture `reg_rdata` into `b_q`, then go to EXEC.
- EXEC: `alu_opcode`/`alu_a`/`alu_b` are already driven from `op_q`/`a_q`/`b_q`. Capture `alu_y` into `res_q`, then go to WB.
- WB: `reg_addr`=`dst_q`, `reg_wr`=1, `reg_wdata`=`res_q`. Go to DONE.
- DONE: `done`=1, `result`=`res_q`. Go to IDLE.
- In every state other than RD_A, RD_B and WB, `reg_rd`=`reg_wr`=0 and `reg_addr`=0.
- `reg_rd` and `reg_wr` are never high together.
- `alu_a`, `alu_b` and `alu_opcode` are driven continuously from `a_q`, `b_q` and `op_q`.
- Arithmetic is entirely inside the ALU. The ALU result is 8-bit, wraps modulo 256, and the sequencer does not modify it.
- `src_a`=`src_b` is legal; the same register is read twice.
- `dst` equal to a source register is legal; the write occurs after both reads.

## Timing
- Reset, applied on the edge where `rst`=1:
  - State = IDLE.
  - `a_q`, `b_q`, `res_q`, `op_q`, `result` = 0.
  - Outputs: `ready`=1, `done`=0, `reg_rd`=`reg_wr`=0, `reg_addr`=0, `reg_wdata`=0, `alu_*`=0.
- ALU command accepted at edge k: RD_A in cycle k+1, RD_B in k+2, EXEC in k+3, WB in k+4, `done` in k+5, `ready` again in k+6. Latency from acceptance to `done` is 5 cycles.
- Load-immediate command: WB in k+1, `done` in k+2, `ready` in k+3.
- A new command can be accepted on the first IDLE cycle, so back-to-back commands occupy 6 cycles each (ALU) or 3 cycles each (load immediate).
- `start` while `ready`=0 is ignored; there is no queuing.
- Command inputs are sampled only at acceptance and may change afterwards.
- Reset mid-command: the FSM returns to IDLE at that edge and no later write occurs. If reset is sampled at the end of the WB cycle, that write has already been presented and is not suppressed; `done` is not pulsed.
- `result` updates on the edge entering DONE and holds until the next DONE.

## Test plan
- Reset -> `ready`=1, `done`=0, `reg_rd`=`reg_wr`=0, `result`=0; hold `rst` high for 3 cycles and confirm the outputs stay constant.
- Load-immediate 0x03 to R0, then 0x02 to R1 -> each `done` comes 2 cycles after acceptance; a single-cycle `reg_wr` with addr 0/data 0x03 and addr 1/data 0x02; `result`=0x03, then 0x02.
- ALU op `opcode`=000 (add), `src_a`=R0, `src_b`=R1, `dst`=R2 -> reads addr 0 then 1, `alu_a`=3, `alu_b`=2, write of 5 to R2, `done` 5 cycles after acceptance, `result`=5. Repeat with 001 (subtract) into R3 -> `result`=1.
- Wrap and aliasing: R0=0xFF, add R0,R0 -> R0 -> `result`=0xFE written to R0. A later read of R0 returns 0xFE.
- `start` held high continuously, plus a pulse during RD_B -> commands are accepted only on `ready` cycles and the mid-command pulse is ignored.
- Reset asserted during EXEC -> no `reg_wr`, no `done`, `ready`=1 on the next cycle, and the destination register is unchanged.
